// File: rtl/ppu_bg_line_fetcher.sv
// Per-scanline background fetch engine: tile map + tile graphics into a ping-pong line buffer.
// Latency: fetch takes 2*(TILES/IDS_PER_WORD)+2*TILES cycles after line_start; pixel path is 1 cycle.
// Backpressure: none; RAMs answer one cycle after a strobe, a new line_start restarts the fetch (overrun).
//
// Ports: clk/reset (sync, active-high); line_start/line_num start a fetch;
//   map_rd/map_addr/map_data and gfx_rd/gfx_addr/gfx_data talk to the tile RAMs;
//   pix_x -> pix_index/pix_palette serve the front half; busy/done/overrun report fetch status.
// Optional: define BG_SCROLL_EN to add scroll_x/scroll_y inputs (sampled at line_start).
module ppu_bg_line_fetcher #(
  parameter int unsigned TILES_PER_LINE = 40,
  parameter int unsigned TILE_PX        = 16,
  parameter int unsigned BPP            = 2,
  parameter int unsigned ID_W           = 7,
  parameter int unsigned MAP_AW         = 9,
  parameter int unsigned GFX_AW         = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        line_num,
`ifdef BG_SCROLL_EN
  input  logic [10:0]       scroll_x,
  input  logic [9:0]        scroll_y,
`endif
  output logic              map_rd,
  output logic [MAP_AW-1:0] map_addr,
  input  logic [31:0]       map_data,
  output logic              gfx_rd,
  output logic [GFX_AW-1:0] gfx_addr,
  input  logic [31:0]       gfx_data,
  input  logic [10:0]       pix_x,
  output logic [BPP-1:0]    pix_index,
  output logic              pix_palette,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned IDB     = ID_W + 1;          // bits per map byte {pal, id}
  localparam int unsigned IDS     = 32 / IDB;          // tile IDs per map word
  localparam int unsigned IDS_LG  = $clog2(IDS);
  localparam int unsigned WORDS   = TILES_PER_LINE / IDS;
  localparam int unsigned TPX_LG  = $clog2(TILE_PX);
  localparam int unsigned LINE_PX = TILES_PER_LINE * TILE_PX;
  localparam int unsigned T_W     = $clog2(TILES_PER_LINE + 1);
  localparam int unsigned TI_W    = $clog2(TILES_PER_LINE);
  localparam int unsigned PXW     = TPX_LG + TI_W;
  localparam logic [T_W-1:0] T_LAST = T_W'(TILES_PER_LINE);

  typedef enum logic [2:0] {IDLE, MAP_REQ, MAP_WAIT, GFX_REQ, GFX_WAIT, DONE} state_t;

  state_t              state_q;
  logic                front_q;
  logic [9:0]          row_q;
  logic [TPX_LG-1:0]   trow_q;
  logic [T_W-1:0]      t_q;
  logic [31:0]         word_q;
  logic                map_rd_q, gfx_rd_q, busy_q, done_q, overrun_q;
  logic [MAP_AW-1:0]   map_addr_q;
  logic [GFX_AW-1:0]   gfx_addr_q;
  logic [31:0]         gfx_buf_q [2][TILES_PER_LINE];
  logic                pal_buf_q [2][TILES_PER_LINE];
  logic [BPP-1:0]      pix_index_q;
  logic                pix_pal_q;
`ifdef BG_SCROLL_EN
  logic [10:0]         scroll_x_q;
`endif

  function automatic logic [MAP_AW-1:0] map_addr_f(input logic [9:0] row, input logic [T_W-1:0] t);
    return MAP_AW'(32'(row) * WORDS + (32'(t) >> IDS_LG));
  endfunction

  function automatic logic [GFX_AW-1:0] gfx_addr_f(input logic [ID_W-1:0] id, input logic [TPX_LG-1:0] trow);
    return GFX_AW'(32'(id) * TILE_PX + 32'(trow));
  endfunction

  // Line latch values for a line_start in this cycle.
  logic [9:0]        eff_line_d, row_d;
  logic [TPX_LG-1:0] trow_d;
  always_comb begin
`ifdef BG_SCROLL_EN
    eff_line_d = line_num + scroll_y;
`else
    eff_line_d = line_num;
`endif
    row_d  = eff_line_d >> TPX_LG;
    trow_d = eff_line_d[TPX_LG-1:0];
  end

  // Tile about to enter GFX_REQ: from MAP_WAIT it is t_q with the word still on map_data;
  // from GFX_WAIT it is t_q+1 with the word already captured.
  logic [T_W-1:0]  t_next_d, gfx_t_d;
  logic [31:0]     src_word_d;
  logic [IDB-1:0]  id_byte_d;
  always_comb begin
    t_next_d   = t_q + 1'b1;
    gfx_t_d    = (state_q == MAP_WAIT) ? t_q : t_next_d;
    src_word_d = (state_q == MAP_WAIT) ? map_data : word_q;
    id_byte_d  = IDB'(src_word_d >> (32'(gfx_t_d[IDS_LG-1:0]) * IDB));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      front_q    <= 1'b0;
      row_q      <= '0;
      trow_q     <= '0;
      t_q        <= '0;
      word_q     <= '0;
      map_rd_q   <= 1'b0;
      gfx_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      map_addr_q <= '0;
      gfx_addr_q <= '0;
`ifdef BG_SCROLL_EN
      scroll_x_q <= '0;
`endif
      for (int h = 0; h < 2; h++) begin
        for (int i = 0; i < int'(TILES_PER_LINE); i++) begin
          gfx_buf_q[h][i] <= '0;
          pal_buf_q[h][i] <= 1'b0;
        end
      end
    end else begin
      map_rd_q  <= 1'b0;
      gfx_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      if (line_start) begin
        // Any state: swap halves and restart; only a fetch still in flight is an overrun.
        overrun_q  <= busy_q;
        front_q    <= ~front_q;
        row_q      <= row_d;
        trow_q     <= trow_d;
        t_q        <= '0;
        state_q    <= MAP_REQ;
        busy_q     <= 1'b1;
        map_rd_q   <= 1'b1;
        map_addr_q <= map_addr_f(row_d, T_W'(0));
`ifdef BG_SCROLL_EN
        scroll_x_q <= scroll_x;
`endif
      end else begin
        case (state_q)
          MAP_REQ: state_q <= MAP_WAIT;
          MAP_WAIT: begin
            word_q     <= map_data;
            state_q    <= GFX_REQ;
            gfx_rd_q   <= 1'b1;
            gfx_addr_q <= gfx_addr_f(id_byte_d[ID_W-1:0], trow_q);
            pal_buf_q[~front_q][gfx_t_d[TI_W-1:0]] <= id_byte_d[ID_W];
          end
          GFX_REQ: state_q <= GFX_WAIT;
          GFX_WAIT: begin
            gfx_buf_q[~front_q][t_q[TI_W-1:0]] <= gfx_data;
            t_q <= t_next_d;
            if (t_next_d == T_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (t_next_d[IDS_LG-1:0] == '0) begin
              state_q    <= MAP_REQ;
              map_rd_q   <= 1'b1;
              map_addr_q <= map_addr_f(row_q, t_next_d);
            end else begin
              state_q    <= GFX_REQ;
              gfx_rd_q   <= 1'b1;
              gfx_addr_q <= gfx_addr_f(id_byte_d[ID_W-1:0], trow_q);
              pal_buf_q[~front_q][gfx_t_d[TI_W-1:0]] <= id_byte_d[ID_W];
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Pixel path: range check uses the unscrolled column; scrolled column wraps within the line.
  logic            in_range_d;
  logic [PXW-1:0]  px_d;
  logic [TI_W-1:0] tile_d;
  logic [31:0]     pix_word_d;
  logic [BPP-1:0]  pix_sel_d;
  always_comb begin
    in_range_d = (32'(pix_x) < LINE_PX);
`ifdef BG_SCROLL_EN
    px_d = PXW'((12'(pix_x) + 12'(scroll_x_q)) % LINE_PX);
`else
    px_d = pix_x[PXW-1:0];
`endif
    tile_d     = in_range_d ? px_d[TPX_LG +: TI_W] : '0;
    pix_word_d = gfx_buf_q[front_q][tile_d];
    pix_sel_d  = BPP'(pix_word_d >> (32'(px_d[TPX_LG-1:0]) * BPP));
  end

  always_ff @(posedge clk) begin
    if (reset || !in_range_d) begin
      pix_index_q <= '0;
      pix_pal_q   <= 1'b0;
    end else begin
      pix_index_q <= pix_sel_d;
      pix_pal_q   <= pal_buf_q[front_q][tile_d];
    end
  end

  assign map_rd      = map_rd_q;
  assign map_addr    = map_addr_q;
  assign gfx_rd      = gfx_rd_q;
  assign gfx_addr    = gfx_addr_q;
  assign pix_index   = pix_index_q;
  assign pix_palette = pix_pal_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ppu_bg_line_fetcher.sv
module tb_ppu_bg_line_fetcher;
  logic        clk = 1'b0;
  logic        reset, line_start;
  logic [9:0]  line_num;
  logic        map_rd, gfx_rd;
  logic [8:0]  map_addr;
  logic [10:0] gfx_addr;
  logic [31:0] map_data, gfx_data;
  logic [10:0] pix_x;
  logic [1:0]  pix_index;
  logic        pix_palette, busy, done, overrun;
`ifdef BG_SCROLL_EN
  logic [10:0] scroll_x;
  logic [9:0]  scroll_y;
`endif

  always #5 clk = ~clk;

  ppu_bg_line_fetcher dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
`ifdef BG_SCROLL_EN
    .scroll_x(scroll_x), .scroll_y(scroll_y),
`endif
    .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
    .gfx_rd(gfx_rd), .gfx_addr(gfx_addr), .gfx_data(gfx_data),
    .pix_x(pix_x), .pix_index(pix_index), .pix_palette(pix_palette),
    .busy(busy), .done(done), .overrun(overrun)
  );

  // RAM models: one-cycle read latency.
  logic [31:0] map_mem [512];
  logic [31:0] gfx_mem [2048];
  always @(posedge clk) begin
    if (map_rd) map_data <= map_mem[map_addr];
    if (gfx_rd) gfx_data <= gfx_mem[gfx_addr];
  end

  // Monitors sample the pre-edge values at each rising edge.
  int cyc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  logic [8:0]  map_log[$];
  logic [10:0] gfx_log[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (map_rd) map_log.push_back(map_addr);
    if (gfx_rd) gfx_log.push_back(gfx_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ln);
    line_num   = 10'(ln);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  // Returns cycles from line_start to the observed done (101 expected).
  task automatic wait_done(input int start, output int lat);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    lat = (done === 1'b1) ? (cyc - start + 1) : -1;
  endtask

  // Reference model: what one line fetch must read and leave in the buffer.
  int          exp_map[$];
  int          exp_gfxa[$];
  logic [31:0] cur_gfx [40];
  logic [31:0] prev_gfx [40];
  logic        cur_pal [40];
  logic        prev_pal [40];

  task automatic build_exp(input int line);
    int row, trow, id, a;
    logic [31:0] w, b;
    exp_map.delete();
    exp_gfxa.delete();
    row  = line / 16;
    trow = line % 16;
    for (int k = 0; k < 10; k++) exp_map.push_back((row * 10 + k) % 512);
    for (int t = 0; t < 40; t++) begin
      w  = map_mem[(row * 10 + t / 4) % 512];
      b  = (w >> (8 * (t % 4))) & 32'hFF;
      id = int'(b % 128);
      a  = (id * 16 + trow) % 2048;
      exp_gfxa.push_back(a);
      cur_gfx[t] = gfx_mem[a];
      cur_pal[t] = (b >= 128);
    end
  endtask

  task automatic check_seqs(input string tag);
    check({tag, "_map_count"}, map_log.size(), exp_map.size());
    check({tag, "_gfx_count"}, gfx_log.size(), exp_gfxa.size());
    for (int i = 0; i < exp_map.size() && i < map_log.size(); i++)
      check({tag, "_map_addr"}, int'(map_log[i]), exp_map[i]);
    for (int i = 0; i < exp_gfxa.size() && i < gfx_log.size(); i++)
      check({tag, "_gfx_addr"}, int'(gfx_log[i]), exp_gfxa[i]);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 512; i++) map_mem[i] = '0;
    for (int i = 0; i < 2048; i++) gfx_mem[i] = '0;
    map_mem[0]     = 32'h8302_0100;
    gfx_mem[11'h000] = 32'h0000_001B;
    gfx_mem[11'h010] = 32'h0000_000E;
    gfx_mem[11'h020] = 32'hFFFF_FFFF;
    gfx_mem[11'h030] = 32'h8000_0000;
  endtask

  typedef struct {
    int       x;
    int       idx;
    int       pal;
  } vec_t;
  vec_t vecs [16];

  initial begin
    int st, lat, dc0, oc0, x, exp_idx, exp_pal, line;

    // Pixel vectors for the line-0 data set loaded by load_directed.
    vecs[0]  = '{0,    3, 0};
    vecs[1]  = '{1,    2, 0};
    vecs[2]  = '{2,    1, 0};
    vecs[3]  = '{3,    0, 0};
    vecs[4]  = '{18,   0, 0};
    vecs[5]  = '{32,   3, 0};
    vecs[6]  = '{47,   3, 0};
    vecs[7]  = '{48,   0, 1};
    vecs[8]  = '{63,   2, 1};
    vecs[9]  = '{640,  0, 0};
    vecs[10] = '{625,  2, 0};
    vecs[11] = '{2047, 0, 0};
    vecs[12] = '{639,  0, 0};
    vecs[13] = '{64,   3, 0};
    vecs[14] = '{17,   3, 0};
    vecs[15] = '{16,   2, 0};

    reset = 1'b1; line_start = 1'b0; line_num = '0; pix_x = '0;
    map_data = '0; gfx_data = '0;
`ifdef BG_SCROLL_EN
    scroll_x = '0; scroll_y = '0;
`endif
    load_directed();
    step(3);
    check("rst_map_rd", map_rd, 0);
    check("rst_gfx_rd", gfx_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pix_index", pix_index, 0);
    check("rst_pix_palette", pix_palette, 0);
    check("rst_map_addr", map_addr, 0);
    check("rst_gfx_addr", gfx_addr, 0);
    reset = 1'b0;
    step(1);

    // Line 0 fetch: address order and done timing.
    map_log.delete(); gfx_log.delete();
    build_exp(0);
    pulse(0); st = cyc;
    check("busy_after_start", busy, 1);
    wait_done(st, lat);
    check("done_latency_line0", lat, 101);
    for (int i = 0; i < 4; i++)
      check("gfx_addr_first4", (gfx_log.size() > i) ? int'(gfx_log[i]) : -1, i * 16);
    check_seqs("line0");

    // line_start during the DONE cycle is a normal start, not an overrun.
    map_log.delete(); gfx_log.delete();
    pulse(37); st = cyc;
    check("no_overrun_in_done", overrun, 0);
    check("busy_line37", busy, 1);

    pix_x = 11'd16; step(1);
    check("pix16_idx", pix_index, 2);
    pix_x = 11'd17; #1;
    check("pix_registered", pix_index, 2);
    step(1);
    check("pix17_idx", pix_index, 3);
    foreach (vecs[i]) begin
      pix_x = 11'(vecs[i].x);
      step(1);
      check($sformatf("vec_idx_x%0d", vecs[i].x), pix_index, vecs[i].idx);
      check($sformatf("vec_pal_x%0d", vecs[i].x), pix_palette, vecs[i].pal);
    end
    check("line37_map_addr0", (map_log.size() > 0) ? int'(map_log[0]) : -1, 20);
    check("line37_gfx_trow", (gfx_log.size() > 0) ? int'(gfx_log[0] & 11'hF) : -1, 5);
    wait_done(st, lat);
    check("done_latency_line37", lat, 101);
    step(3);

    // Overrun: restart at cycle 50 of a fetch.
    dc0 = done_cnt; oc0 = ovr_cnt;
    pulse(5);
    step(49);
    pulse(9); st = cyc;
    check("overrun_pulse", overrun, 1);
    wait_done(st, lat);
    check("done_latency_restart", lat, 101);
    step(1);
    check("overrun_count", ovr_cnt - oc0, 1);
    check("done_count_restart", done_cnt - dc0, 1);

    // Reset in the middle of a fetch.
    for (int i = 0; i < 2048; i++) gfx_mem[i] = 32'hFFFF_FFFF;
    pix_x = 11'd16;
    pulse(3);
    step(29);
    reset = 1'b1;
    step(1);
    check("midrst_busy", busy, 0);
    check("midrst_map_rd", map_rd, 0);
    check("midrst_gfx_rd", gfx_rd, 0);
    check("midrst_pix_index", pix_index, 0);
    check("midrst_done", done, 0);
    dc0 = done_cnt;
    step(2);
    reset = 1'b0;
    pix_x = 11'd0;
    step(1);
    check("midrst_buf_cleared", pix_index, 0);
    step(150);
    check("midrst_no_done", done_cnt - dc0, 0);

    // Random lines against the reference model.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 512; i++) map_mem[i] = $urandom;
      for (int i = 0; i < 2048; i++) gfx_mem[i] = $urandom;
      line = int'($urandom_range(0, 1023));
      build_exp(line);
      map_log.delete(); gfx_log.delete();
      pulse(line); st = cyc;
      if (it > 0) begin
        for (int p = 0; p < 24; p++) begin
          x = int'($urandom_range(0, 700));
          pix_x = 11'(x);
          step(1);
          if (x >= 640) begin
            exp_idx = 0; exp_pal = 0;
          end else begin
            exp_idx = int'((prev_gfx[x / 16] >> (2 * (x % 16))) & 32'h3);
            exp_pal = int'(prev_pal[x / 16]);
          end
          check("rand_pix_index", pix_index, exp_idx);
          check("rand_pix_palette", pix_palette, exp_pal);
        end
      end
      wait_done(st, lat);
      check("rand_done_latency", lat, 101);
      check_seqs("rand");
      prev_gfx = cur_gfx;
      prev_pal = cur_pal;
      step(2);
    end

`ifdef BG_SCROLL_EN
    load_directed();
    pulse(0); st = cyc;
    wait_done(st, lat);
    step(2);
    scroll_x = 11'd4;
    pulse(37); st = cyc;
    pix_x = 11'd12;
    step(1);
    check("scroll_pix_index", pix_index, 2);
    wait_done(st, lat);
    scroll_x = '0;
    step(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
